// File: rtl/alu_seq_ctrl.sv
// Sequencer for a downstream registered ALU: issues two-operand instructions out of
// an 8-entry register file and writes the ALU result back; exposes a host port.
module alu_seq_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [11:0]  instr,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [2:0]   rd_addr,
  output logic [N-1:0] rd_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_select,
  input  logic [N-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_ov,
  input  logic         alu_c,
  output logic         done,
  output logic         err,
  output logic         flag_z,
  output logic         flag_ov,
  output logic         flag_c
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WB    = 2'd2;

  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      3'b010:  ok = 1'b0;
      3'b111:  ok = 1'b0;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [11:0]  instr_q, instr_d;
  logic [N-1:0] rf_q [8];
  logic [N-1:0] rf_d [8];
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_select_q, alu_select_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         flag_z_q, flag_z_d;
  logic         flag_ov_q, flag_ov_d;
  logic         flag_c_q, flag_c_d;

  // Sequencing, operand capture, pulses and flag updates.
  // A host write landing on the same accept edge is forwarded into the operands.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_select_d = 3'b000;
    done_d       = 1'b0;
    err_d        = 1'b0;
    flag_z_d     = flag_z_q;
    flag_ov_d    = flag_ov_q;
    flag_c_d     = flag_c_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          if (op_legal(instr[11:9])) begin
            state_d      = ISSUE;
            alu_select_d = instr[11:9];
            alu_a_d      = (wr_en && (wr_addr == instr[5:3])) ? wr_data : rf_q[instr[5:3]];
            alu_b_d      = (wr_en && (wr_addr == instr[2:0])) ? wr_data : rf_q[instr[2:0]];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WB;
        done_d  = 1'b1;
      end
      WB: begin
        state_d  = IDLE;
        flag_z_d = alu_z;
        if (instr_q[11:9] == OP_SUB) begin
          flag_ov_d = alu_ov;
        end else begin
          flag_ov_d = flag_ov_q;
        end
        if (instr_q[11:9] == OP_ADD) begin
          flag_c_d = alu_c;
        end else begin
          flag_c_d = flag_c_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-file next state: host writes only in IDLE, ALU write-back in WB.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rf_d[i] = rf_q[i];
    end
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          rf_d[wr_addr] = wr_data;
        end else begin
          rf_d[wr_addr] = rf_q[wr_addr];
        end
      end
      WB:      rf_d[instr_q[8:6]] = alu_result;
      default: rf_d[0] = rf_q[0];
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= 12'h000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= 3'b000;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_ov_q    <= 1'b0;
      flag_c_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
      done_q       <= done_d;
      err_q        <= err_d;
      flag_z_q     <= flag_z_d;
      flag_ov_q    <= flag_ov_d;
      flag_c_q     <= flag_c_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Ready is gated by rst_n so it reads low throughout reset.
  assign instr_ready = rst_n && (state_q == IDLE);
  assign rd_data     = rf_q[rd_addr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_select  = alu_select_q;
  assign done        = done_q;
  assign err         = err_q;
  assign flag_z      = flag_z_q;
  assign flag_ov     = flag_ov_q;
  assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a registered ALU stub and a write-back scoreboard.
module tb_alu_seq_ctrl;

  localparam int N = 32;
  localparam logic [2:0] MOV = 3'b000, NOT = 3'b001, AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100, SUB = 3'b101, ADD = 3'b110;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [11:0]  instr = 12'h000;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = 3'd0;
  logic [N-1:0] wr_data = '0;
  logic [2:0]   rd_addr = 3'd0;
  logic [N-1:0] rd_data;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_select;
  logic [N-1:0] alu_result = '0;
  logic         alu_z = 1'b0, alu_ov = 1'b0, alu_c = 1'b0;
  logic         done, err, flag_z, flag_ov, flag_c;

  alu_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_result(alu_result), .alu_z(alu_z),
    .alu_ov(alu_ov), .alu_c(alu_c), .done(done), .err(err),
    .flag_z(flag_z), .flag_ov(flag_ov), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {ov, c, result}; ov/c are driven for ADD and SUB alike
  function automatic logic [N+1:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, b);
    logic [N-1:0] r;
    logic         ov, c;
    logic [N:0]   wide;
    r = '0; ov = 1'b0; c = 1'b0;
    case (op)
      MOV: r = a;
      NOT: r = ~a;
      AND: r = a & b;
      OR:  r = a | b;
      SUB: begin
        r  = a - b;
        c  = (a < b);
        ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[N-1:0];
        c    = wide[N];
        ov   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      default: r = '0;
    endcase
    return {ov, c, r};
  endfunction

  // Registered ALU stub
  always @(posedge clk) begin
    logic [N+1:0] f;
    f = alu_f(alu_select, alu_a, alu_b);
    alu_result <= f[N-1:0];
    alu_c      <= f[N];
    alu_ov     <= f[N+1];
    alu_z      <= (f[N-1:0] == '0);
  end

  typedef struct {
    logic [2:0]   rd;
    logic [N-1:0] val;
    logic         z, ov, c;
  } sb_t;

  sb_t          sb[$];
  logic [N-1:0] sh_rf [8];
  logic         sh_z, sh_ov, sh_c;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shadow_reset();
    for (int i = 0; i < 8; i++) sh_rf[i] = '0;
    sh_z = 1'b0; sh_ov = 1'b0; sh_c = 1'b0;
    sb.delete();
  endtask

  // Model the instruction at accept time and queue the expected write-back
  task automatic issue_push(input logic [2:0] op, rd, rs1, rs2);
    logic [N+1:0] f;
    sb_t          e;
    f    = alu_f(op, sh_rf[rs1], sh_rf[rs2]);
    sh_z = (f[N-1:0] == '0);
    if (op == SUB) sh_ov = f[N+1];
    if (op == ADD) sh_c  = f[N];
    sh_rf[rd] = f[N-1:0];
    e.rd = rd; e.val = f[N-1:0]; e.z = sh_z; e.ov = sh_ov; e.c = sh_c;
    sb.push_back(e);
  endtask

  // Called in the cycle after WB: compare rf[rd] and flags against the oldest entry
  task automatic check_pop(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      rd_addr = e.rd;
      #1;
      chk({tag, "_rd"}, rd_data, e.val);
      chk({tag, "_fz"}, flag_z, e.z);
      chk({tag, "_fov"}, flag_ov, e.ov);
      chk({tag, "_fc"}, flag_c, e.c);
    end
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("%s_rf%0d", tag, i), rd_data, sh_rf[i]);
    end
  endtask

  task automatic hw(input logic [2:0] a, input logic [N-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    sh_rf[a] = d;
  endtask

  // One instruction, with optional same-cycle host write; junk host writes during ISSUE/WB
  task automatic exec(input string tag, input logic [2:0] op, rd, rs1, rs2,
                      input logic we = 1'b0, input logic [2:0] wa = 3'd0,
                      input logic [N-1:0] wd = '0);
    logic [N-1:0] ea, eb;
    @(negedge clk);
    instr = {op, rd, rs1, rs2}; instr_valid = 1'b1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    chk({tag, "_ready_idle"}, instr_ready, 1'b1);
    if (we) sh_rf[wa] = wd;
    ea = sh_rf[rs1]; eb = sh_rf[rs2];
    issue_push(op, rd, rs1, rs2);
    @(negedge clk);
    instr_valid = 1'b0; instr = ~instr;
    wr_en = 1'b1; wr_addr = rs1; wr_data = 32'hDEADBEEF;
    chk({tag, "_issue_a"}, alu_a, ea);
    chk({tag, "_issue_b"}, alu_b, eb);
    chk({tag, "_issue_sel"}, alu_select, op);
    chk({tag, "_issue_ready"}, instr_ready, 1'b0);
    chk({tag, "_issue_done"}, done, 1'b0);
    @(negedge clk);
    chk({tag, "_wb_done"}, done, 1'b1);
    chk({tag, "_wb_ready"}, instr_ready, 1'b0);
    chk({tag, "_wb_a"}, alu_a, 32'h0);
    chk({tag, "_wb_sel"}, alu_select, 3'b000);
    @(negedge clk);
    wr_en = 1'b0;
    chk({tag, "_post_done"}, done, 1'b0);
    chk({tag, "_post_ready"}, instr_ready, 1'b1);
    check_pop(tag);
  endtask

  task automatic illegal(input string tag, input logic [2:0] op);
    @(negedge clk);
    instr = {op, 3'd3, 3'd1, 3'd2}; instr_valid = 1'b1;
    chk({tag, "_ready"}, instr_ready, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_err"}, err, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ready_after"}, instr_ready, 1'b1);
    chk({tag, "_alu_sel"}, alu_select, 3'b000);
    @(negedge clk);
    chk({tag, "_err_clear"}, err, 1'b0);
    chk({tag, "_done_after"}, done, 1'b0);
    check_rf(tag);
  endtask

  initial begin
    shadow_reset();
    @(negedge clk);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_sel", alu_select, 3'b000);
    chk("rst_flags", {flag_z, flag_ov, flag_c}, 3'b000);
    check_rf("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_ready", instr_ready, 1'b1);

    hw(3'd1, 32'd5); hw(3'd2, 32'd3);
    exec("add_5_3", ADD, 3'd3, 3'd1, 3'd2);
    rd_addr = 3'd3; #1;
    chk("add_5_3_const", rd_data, 32'd8);
    chk("add_5_3_fc", flag_c, 1'b0);
    chk("add_5_3_fz", flag_z, 1'b0);

    hw(3'd1, 32'd3); hw(3'd2, 32'd3);
    exec("sub_eq", SUB, 3'd4, 3'd1, 3'd2);
    rd_addr = 3'd4; #1;
    chk("sub_eq_const", rd_data, 32'd0);
    chk("sub_eq_fz", flag_z, 1'b1);
    hw(3'd1, 32'h8000_0000); hw(3'd2, 32'd1);
    exec("sub_ov", SUB, 3'd4, 3'd1, 3'd2);
    rd_addr = 3'd4; #1;
    chk("sub_ov_const", rd_data, 32'h7FFF_FFFF);
    chk("sub_ov_fov", flag_ov, 1'b1);

    hw(3'd1, 32'hFFFF_FFFF); hw(3'd2, 32'd1);
    exec("add_carry", ADD, 3'd3, 3'd1, 3'd2);
    rd_addr = 3'd3; #1;
    chk("add_carry_const", rd_data, 32'h0);
    chk("add_carry_fc", flag_c, 1'b1);
    chk("add_carry_fz", flag_z, 1'b1);
    exec("or_keepc", OR, 3'd6, 3'd1, 3'd2);
    chk("or_keepc_fc", flag_c, 1'b1);

    exec("and_rd_rs1", AND, 3'd1, 3'd1, 3'd2);
    exec("not", NOT, 3'd7, 3'd1, 3'd0);
    exec("mov", MOV, 3'd0, 3'd7, 3'd7);
    exec("wr_accept", ADD, 3'd2, 3'd2, 3'd2, 1'b1, 3'd2, 32'h10);
    rd_addr = 3'd2; #1;
    chk("wr_accept_const", rd_data, 32'h20);
    check_rf("after_ops");

    illegal("ill_111", 3'b111);
    illegal("ill_010", 3'b010);

    // Back-to-back with instr_valid held high and junk host writes while busy
    hw(3'd1, 32'd1); hw(3'd6, 32'd10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        instr = {ADD, 3'd6, 3'd6, 3'd1};
        instr_valid = 1'b1;
      end
      wr_en = (k % 3 != 0) && (k < 9); wr_addr = 3'd5; wr_data = 32'hBAD0_0000 + 32'(k);
      if (k == 9) instr_valid = 1'b0;
      if (k == 3 || k == 6 || k == 9) check_pop($sformatf("b2b_%0d", k));
      chk($sformatf("b2b_ready_%0d", k), instr_ready, (k % 3 == 0));
      chk($sformatf("b2b_done_%0d", k), done, (k % 3 == 2));
      if (k % 3 == 0 && k < 9) issue_push(ADD, 3'd6, 3'd6, 3'd1);
    end
    rd_addr = 3'd6; #1;
    chk("b2b_const", rd_data, 32'd13);
    check_rf("b2b");

    // Reset during ISSUE aborts the instruction
    hw(3'd1, 32'd2); hw(3'd2, 32'd2);
    @(negedge clk);
    instr = {ADD, 3'd5, 3'd1, 3'd2}; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rst_issue_sel_pre", alu_select, ADD);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", instr_ready, 1'b0);
    chk("rst_mid_alu_a", alu_a, 32'h0);
    chk("rst_mid_sel", alu_select, 3'b000);
    chk("rst_mid_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    shadow_reset();
    #1 chk("rst_mid_release_ready", instr_ready, 1'b1);
    @(negedge clk);
    chk("rst_mid_done1", done, 1'b0);
    chk("rst_mid_ready1", instr_ready, 1'b1);
    @(negedge clk);
    chk("rst_mid_done2", done, 1'b0);
    chk("rst_mid_flags", {flag_z, flag_ov, flag_c}, 3'b000);
    check_rf("rst_mid");
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
